// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the BCD counter family.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } bcd_dn_state_t;

    // Any non-BCD nibble (10..15) is treated as the largest legal digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One combinational BCD digit slice for the down-counter: decrements on
// request, rolling 0 over to 9, and reports whether the digit is zero.
module bcd_digit_dn
    import bcd_pkg::*;
(
    input  logic       dec_in,
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out,
    output logic       is_zero
);

    // Next digit value; zero-detect feeds the borrow chain of higher digits.
    always_comb begin
        is_zero   = (digit_in == 4'd0);
        digit_out = digit_in;
        if (dec_in) begin
            digit_out = is_zero ? BCD_MAX : (digit_in - 4'd1);
        end
    end

endmodule

// File: rtl/bcd_down_ctr.sv
// Multi-digit BCD countdown timer: loads a sanitised preset, decrements one
// step per enabled clock, pulses tc when reaching zero, then stops or wraps.
module bcd_down_ctr
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  wrap,
    output logic [4*DIGITS-1:0]   out,
    output logic                  busy,
    output logic                  zero,
    output logic                  tc
);

    bcd_dn_state_t         state_q, state_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic [4*DIGITS-1:0]   dec_count;
    logic [4*DIGITS-1:0]   load_clamped;
    logic [DIGITS-1:0]     dec;
    logic [DIGITS-1:0]     is_zero;
    logic                  tc_q, tc_d;
    logic                  busy_q, busy_d;
    logic                  dec_req;
    logic                  cur_zero;
    logic                  dec_zero;
    logic                  load_zero;

    assign cur_zero  = &is_zero;
    assign dec_zero  = (dec_count == '0);
    assign load_zero = (load_clamped == '0);

    // A real decrement happens only in RUN with en, no load, and not when
    // sitting at zero with wrap low (that case just retires to EXPIRED).
    assign dec_req = (state_q == RUN) && en && !load && !(cur_zero && !wrap);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign load_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);

        if (i == 0) begin : g_lsd
            assign dec[i] = dec_req;
        end else begin : g_upper
            // Borrow reaches digit i once every lower digit is zero.
            assign dec[i] = dec_req & (&is_zero[i-1:0]);
        end

        bcd_digit_dn u_digit (
            .dec_in    (dec[i]),
            .digit_in  (count_q[4*i +: 4]),
            .digit_out (dec_count[4*i +: 4]),
            .is_zero   (is_zero[i])
        );
    end

    // Next-state logic: load has priority, then the RUN-state count step.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_clamped;
            state_d = load_zero ? EXPIRED : RUN;
        end else if (state_q == RUN && en) begin
            if (cur_zero && !wrap) begin
                state_d = EXPIRED;
            end else begin
                count_d = dec_count;
                if (dec_zero) begin
                    tc_d = 1'b1;
                    if (!wrap) begin
                        state_d = EXPIRED;
                    end
                end
            end
        end
        busy_d = (state_d == RUN);
    end

    // State, count, terminal-count pulse and busy flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = count_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign zero = cur_zero;

endmodule

// File: tb/tb_bcd_down_ctr.sv
// Randomised and directed bench for the 2-digit BCD countdown timer,
// compared against a decimal-arithmetic reference model.
module tb_bcd_down_ctr;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       wrap;
    logic [7:0] dut_out;
    logic       busy;
    logic       zero;
    logic       tc;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: decimal value 0..99, mode 0=idle 1=run 2=expired.
    int m_val  = 0;
    int m_mode = 0;
    bit m_tc   = 0;

    bcd_down_ctr #(.DIGITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .wrap     (wrap),
        .out      (dut_out),
        .busy     (busy),
        .zero     (zero),
        .tc       (tc)
    );

    // Free-running clock; first rising edge at 10 ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_val  = 0;
        m_mode = 0;
        m_tc   = 0;
    endtask

    task automatic model_step();
        int lv;
        m_tc = 0;
        if (load) begin
            lv     = clamp9(int'(load_val[7:4])) * 10 + clamp9(int'(load_val[3:0]));
            m_val  = lv;
            m_mode = (lv == 0) ? 2 : 1;
        end else if (m_mode == 1 && en) begin
            if (m_val == 0) begin
                if (wrap) m_val = 99;
                else      m_mode = 2;
            end else begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_tc = 1;
                    if (!wrap) m_mode = 2;
                end
            end
        end
    endtask

    // Advance one clock with the currently driven inputs, then settle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; load_val = 8'h00; en = 1'b0; wrap = 1'b0;
        #1 reset = 1'b0;
        model_reset();
        #4;
        n_vec++;
        if (dut_out !== 8'h00) begin
            $display("[TB] FAIL reset_out: got %h want 00", dut_out); n_err++;
        end
        n_vec++;
        if (zero !== 1'b1) begin
            $display("[TB] FAIL reset_zero: got %b want 1", zero); n_err++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            $display("[TB] FAIL reset_busy: got %b want 0", busy); n_err++;
        end
        n_vec++;
        if (tc !== 1'b0) begin
            $display("[TB] FAIL reset_tc: got %b want 0", tc); n_err++;
        end
        #1 reset = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_vec++;
            if (dut_out !== 8'h00 || busy !== 1'b0) begin
                $display("[TB] FAIL idle_ignores_en: got out=%h busy=%b want 00/0", dut_out, busy);
                n_err++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_borrow();
        wrap = 1'b0; load = 1'b1; load_val = 8'h12; en = 1'b1;
        cycle();
        n_vec++;
        if (dut_out !== 8'h12 || busy !== 1'b1) begin
            $display("[TB] FAIL borrow_load: got out=%h busy=%b want 12/1", dut_out, busy); n_err++;
        end
        load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            n_vec++;
            if (dut_out !== to_bcd(m_val) || tc !== m_tc || busy !== (m_mode == 1)) begin
                $display("[TB] FAIL borrow_step%0d: got out=%h tc=%b busy=%b want %h/%b/%b",
                         i, dut_out, tc, busy, to_bcd(m_val), m_tc, (m_mode == 1));
                n_err++;
            end
            n_vec++;
            if (tc !== (dut_out == 8'h00 && i == 11)) begin
                $display("[TB] FAIL borrow_tc_pos%0d: got tc=%b out=%h", i, tc, dut_out); n_err++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_o [4];
        bit         exp_t [4];
        exp_o = '{8'h01, 8'h00, 8'h99, 8'h98};
        exp_t = '{1'b0, 1'b1, 1'b0, 1'b0};
        wrap = 1'b1; load = 1'b1; load_val = 8'h02; en = 1'b0;
        cycle();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_vec++;
            if (dut_out !== exp_o[i] || tc !== exp_t[i] || busy !== 1'b1) begin
                $display("[TB] FAIL wrap_step%0d: got out=%h tc=%b busy=%b want %h/%b/1",
                         i, dut_out, tc, busy, exp_o[i], exp_t[i]);
                n_err++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_change();
        wrap = 1'b1; load = 1'b1; load_val = 8'h01; en = 1'b0;
        cycle();
        load = 1'b0; en = 1'b1;
        cycle();
        n_vec++;
        if (dut_out !== 8'h00 || tc !== 1'b1 || busy !== 1'b1) begin
            $display("[TB] FAIL wrapchg_zero: got out=%h tc=%b busy=%b want 00/1/1", dut_out, tc, busy); n_err++;
        end
        wrap = 1'b0;
        cycle();
        n_vec++;
        if (dut_out !== 8'h00 || tc !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL wrapchg_expire: got out=%h tc=%b busy=%b want 00/0/0", dut_out, tc, busy); n_err++;
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        wrap = 1'b0; load = 1'b1; load_val = 8'h50; en = 1'b0;
        cycle();
        load = 1'b0; en = 1'b1;
        cycle(); cycle();
        load = 1'b1; load_val = 8'hA5;
        cycle();
        n_vec++;
        if (dut_out !== 8'h95 || tc !== 1'b0 || busy !== 1'b1) begin
            $display("[TB] FAIL load_clamp: got out=%h tc=%b busy=%b want 95/0/1", dut_out, tc, busy); n_err++;
        end
        load_val = 8'h00;
        cycle();
        n_vec++;
        if (dut_out !== 8'h00 || tc !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
            $display("[TB] FAIL load_zero: got out=%h tc=%b busy=%b zero=%b want 00/0/0/1",
                     dut_out, tc, busy, zero);
            n_err++;
        end
        load = 1'b0;
        cycle();
        n_vec++;
        if (dut_out !== 8'h00 || tc !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL expired_hold: got out=%h tc=%b busy=%b want 00/0/0", dut_out, tc, busy); n_err++;
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        wrap = 1'b0; load = 1'b1; load_val = 8'h40; en = 1'b0;
        cycle();
        load = 1'b0; en = 1'b1;
        cycle(); cycle(); cycle();
        n_vec++;
        if (dut_out !== 8'h37) begin
            $display("[TB] FAIL areset_pre: got out=%h want 37", dut_out); n_err++;
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (dut_out !== 8'h00 || busy !== 1'b0 || tc !== 1'b0 || zero !== 1'b1) begin
            $display("[TB] FAIL areset_now: got out=%h busy=%b tc=%b zero=%b want 00/0/0/1",
                     dut_out, busy, tc, zero);
            n_err++;
        end
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_enable_gaps();
        bit en_pat [5];
        en_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        wrap = 1'b0; load = 1'b1; load_val = 8'h03; en = 1'b0;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = en_pat[i];
            cycle();
            n_vec++;
            if (dut_out !== to_bcd(m_val) || tc !== (i == 4)) begin
                $display("[TB] FAIL gaps_step%0d: got out=%h tc=%b want %h/%b",
                         i, dut_out, tc, to_bcd(m_val), (i == 4));
                n_err++;
            end
        end
        n_vec++;
        if (dut_out !== 8'h00) begin
            $display("[TB] FAIL gaps_final: got out=%h want 00", dut_out); n_err++;
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load     = ($urandom_range(0, 99) < 8);
            load_val = 8'($urandom_range(0, 255));
            en       = ($urandom_range(0, 3) != 0);
            wrap     = ($urandom_range(0, 4) != 0);
            cycle();
            n_vec++;
            if (dut_out !== to_bcd(m_val) || tc !== m_tc || busy !== (m_mode == 1) ||
                zero !== (m_val == 0)) begin
                $display("[TB] FAIL random%0d: got out=%h tc=%b busy=%b zero=%b want %h/%b/%b/%b",
                         i, dut_out, tc, busy, zero, to_bcd(m_val), m_tc, (m_mode == 1), (m_val == 0));
                n_err++;
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_borrow();
        test_wrap();
        test_wrap_change();
        test_load_priority();
        test_async_reset();
        test_enable_gaps();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
